// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Integer register file for the R4 core. Supplies the alu in1/in2 operands
//   through two combinational read ports and accepts writeback (alu result or
//   load data) through one synchronous write port. x0 is hardwired to zero
//   and has no storage; indices at or above NREGS read as zero and ignore
//   writes, so an RV32E build (NREGS=16) never aliases high indices onto low
//   registers.
//
// Parameters
//   XLEN   data width of each register and every data port
//   NREGS  number of architectural registers (16 or 32)
//
// Ports
//   clk       in   1     clock, state updates on rising edge
//   rst_n     in   1     asynchronous active-low reset, clears all registers
//   rs1_addr  in   5     read port 1 index
//   rs2_addr  in   5     read port 2 index
//   rs1_data  out  XLEN  read port 1 data
//   rs2_data  out  XLEN  read port 2 data
//   we        in   1     write enable
//   rd_addr   in   5     write index
//   rd_data   in   XLEN  write data
//
// Compile-time option
//   REGFILE_BYPASS_EN  when defined, each read port forwards rd_data in the
//                      same cycle it is being written to the addressed
//                      register (never for x0, out-of-range indices, or
//                      while reset is asserted).
// ---------------------------------------------------------------------------
module reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            we,
   input  logic [4:0]      rd_addr,
   input  logic [XLEN-1:0] rd_data
);

   // Storage for x1..x(NREGS-1) only; x0 is synthesised as a constant.
   logic [XLEN-1:0] r_regs [1:NREGS-1];

   logic            w_rdValid;
   logic [XLEN-1:0] w_rs1Stored;
   logic [XLEN-1:0] w_rs2Stored;

   // The write index is legal only if it names a stored register. Matching
   // against each implemented index (rather than a magnitude compare) keeps
   // x0 and every index >= NREGS out in one step.
   always_comb begin
      w_rdValid = 1'b0;
      for (int i = 1; i < NREGS; i++) begin
         if (rd_addr == 5'(i)) begin
            w_rdValid = 1'b1;
         end
      end
   end

   // Register array update. Reset clears everything immediately regardless
   // of the clock, so a write presented alongside reset is simply lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (we && w_rdValid) begin
         for (int i = 1; i < NREGS; i++) begin
            if (rd_addr == 5'(i)) begin
               r_regs[i] <= rd_data;
            end
         end
      end
   end

   // Read muxes over stored state. Starting from zero and only overriding on
   // a match to an implemented index makes x0 and out-of-range reads return
   // zero without any extra decode, and never X.
   always_comb begin
      w_rs1Stored = '0;
      w_rs2Stored = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (rs1_addr == 5'(i)) begin
            w_rs1Stored = r_regs[i];
         end
         if (rs2_addr == 5'(i)) begin
            w_rs2Stored = r_regs[i];
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Same-cycle forwarding: a read of the register being written sees the
   // incoming value. Gated by rst_n because a write during reset never lands.
   always_comb begin
      rs1_data = w_rs1Stored;
      rs2_data = w_rs2Stored;
      if (rst_n && we && w_rdValid) begin
         if (rs1_addr == rd_addr) begin
            rs1_data = rd_data;
         end
         if (rs2_addr == rd_addr) begin
            rs2_data = rd_data;
         end
      end
   end
`else
   // Without forwarding the ports show stored state directly; a same-cycle
   // write becomes visible only after the clock edge.
   always_comb begin
      rs1_data = w_rs1Stored;
      rs2_data = w_rs2Stored;
   end
`endif

endmodule

// File: tb/tb_reg_file.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_reg_file
//   Drives a 32-entry and a 16-entry reg_file from shared inputs and compares
//   every read port against an array-based reference model.
// ---------------------------------------------------------------------------
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  rs1Addr = '0;
   logic [4:0]  rs2Addr = '0;
   logic [4:0]  rdAddr = '0;
   logic [31:0] rdData = '0;
   logic [31:0] rs1Data32, rs2Data32, rs1Data16, rs2Data16;

   int total = 0;
   int bad = 0;

   // Reference contents of each register file; index 0 is kept at zero.
   logic [31:0] m32 [32];
   logic [31:0] m16 [16];

   always #5 clk = ~clk;

   reg_file #(.XLEN(32), .NREGS(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr(rs1Addr), .rs2_addr(rs2Addr),
      .rs1_data(rs1Data32), .rs2_data(rs2Data32),
      .we(we), .rd_addr(rdAddr), .rd_data(rdData)
   );

   reg_file #(.XLEN(32), .NREGS(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr(rs1Addr), .rs2_addr(rs2Addr),
      .rs1_data(rs1Data16), .rs2_data(rs2Data16),
      .we(we), .rd_addr(rdAddr), .rd_data(rdData)
   );

   // Expected read value for a file of n registers at address a, given the
   // inputs currently being driven.
   function automatic logic [31:0] expRead(input int n, input logic [4:0] a);
      logic [31:0] v;
      if (a == 5'd0 || int'(a) >= n) begin
         v = '0;
      end else if (n == 32) begin
         v = m32[a];
      end else begin
         v = m16[a[3:0]];
      end
`ifdef REGFILE_BYPASS_EN
      if (rst_n && we && rdAddr == a && rdAddr != 5'd0 && int'(rdAddr) < n) begin
         v = rdData;
      end
`endif
      return v;
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 32; i++) m32[i] = '0;
      for (int i = 0; i < 16; i++) m16[i] = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_rs1_32"}, rs1Data32, expRead(32, rs1Addr));
      checkOutput({tag, "_rs2_32"}, rs2Data32, expRead(32, rs2Addr));
      checkOutput({tag, "_rs1_16"}, rs1Data16, expRead(16, rs1Addr));
      checkOutput({tag, "_rs2_16"}, rs2Data16, expRead(16, rs2Addr));
   endtask

   // One clock cycle: drive on the falling edge, check before the rising
   // edge, then retire the write into the model at the rising edge.
   task automatic applyStimulus(input string tag, input logic w, input logic [4:0] rd,
                                input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      we = w; rdAddr = rd; rdData = d; rs1Addr = a1; rs2Addr = a2;
      #1;
      checkAll(tag);
      @(posedge clk);
      if (rst_n && w) begin
         if (rd != 5'd0) m32[rd] = d;
         if (rd != 5'd0 && rd < 5'd16) m16[rd[3:0]] = d;
      end
   endtask

   initial begin
      logic [31:0] keep4;
      clearModel();
      $display("[TB] start");

      // Reset asserted from time zero: outputs must be zero, not X.
      #1;
      checkOutput("por_rs1", rs1Data32, 32'h0);
      checkOutput("por_rs2", rs2Data32, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Preload every register, then assert reset between edges and sweep.
      for (int i = 1; i < 32; i++) begin
         applyStimulus("preload", 1'b1, 5'(i), $urandom | 32'h1, 5'(i - 1), 5'(i));
      end
      @(negedge clk);
      we = 1'b0;
      rst_n = 1'b0;
      clearModel();
      for (int i = 1; i < 32; i++) begin
         rs1Addr = 5'(i); rs2Addr = 5'(i);
         #0.1;
         checkOutput($sformatf("rst_rs1_%0d", i), rs1Data32, 32'h0);
         checkOutput($sformatf("rst_rs2_%0d", i), rs2Data32, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write then dual read of the same register; operand pair for add.
      applyStimulus("wr5", 1'b1, 5'd5, 32'h000000FF, 5'd5, 5'd5);
      applyStimulus("wr6", 1'b1, 5'd6, 32'h00000001, 5'd5, 5'd5);
      @(negedge clk);
      we = 1'b0; rs1Addr = 5'd5; rs2Addr = 5'd5;
      #1;
      checkOutput("rd5_rs1", rs1Data32, 32'h000000FF);
      checkOutput("rd5_rs2", rs2Data32, 32'h000000FF);
      rs2Addr = 5'd6;
      #1;
      checkOutput("alu_add", rs1Data32 + rs2Data32, 32'h00000100);

      // Writes to x0 are dropped and disturb nothing.
      applyStimulus("wr_x0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
      for (int i = 0; i < 32; i += 2) begin
         applyStimulus("sweep", 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
      end
      checkOutput("x0_const", rs1Data32 | rs1Data16, 32'h0);

      // Same-cycle write/read hazard on x7.
      applyStimulus("wr7a", 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
      @(negedge clk);
      we = 1'b1; rdAddr = 5'd7; rdData = 32'h2; rs1Addr = 5'd7; rs2Addr = 5'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      checkOutput("hazard_pre", rs1Data32, 32'h2);
`else
      checkOutput("hazard_pre", rs1Data32, 32'h1);
`endif
      @(posedge clk);
      m32[7] = 32'h2; m16[7] = 32'h2;
      @(negedge clk);
      we = 1'b0;
      #1;
      checkOutput("hazard_post", rs1Data32, 32'h2);

      // Reset in the middle of operation with a write pending.
      applyStimulus("wr3", 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
      @(negedge clk);
      rst_n = 1'b0; we = 1'b1; rdAddr = 5'd3; rdData = 32'h1; rs1Addr = 5'd3;
      clearModel();
      #1;
      checkOutput("midrst_now", rs1Data32, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("midrst_edge", rs1Data32, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; we = 1'b0;
      applyStimulus("wr3_after", 1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
      @(negedge clk);
      we = 1'b0; rs1Addr = 5'd3;
      #1;
      checkOutput("midrst_rel", rs1Data32, 32'h1);

      // Out-of-range index on the 16-entry file must not alias onto x4.
      applyStimulus("wr4", 1'b1, 5'd4, 32'h12345678, 5'd4, 5'd4);
      keep4 = m16[4];
      applyStimulus("wr20", 1'b1, 5'd20, 32'hDEADBEEF, 5'd20, 5'd4);
      @(negedge clk);
      we = 1'b0; rs1Addr = 5'd20; rs2Addr = 5'd4;
      #1;
      checkOutput("oor16_rd20", rs1Data16, 32'h0);
      checkOutput("oor16_rd4", rs2Data16, keep4);
      checkOutput("full32_rd20", rs1Data32, 32'hDEADBEEF);

      // Random traffic, including back-to-back writes and out-of-range indices.
      for (int n = 0; n < 400; n++) begin
         applyStimulus("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 32; i += 2) begin
         applyStimulus("final", 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
